// File: rtl/display_mode_ctrl.sv
// Mode sequencer and display-source arbiter in front of the VGA digit renderer.
// Edge-detects the buttons, steps the mode/set FSM and registers the selected segment source.
module display_mode_ctrl #(
    parameter int BLINK_MS   = 500,
    parameter int TIMEOUT_MS = 10000,
    parameter int CNT_W      = 14
) (
    input  logic        CLK,
    input  logic        RST_BTN,
    input  logic        tick_ms,
    input  logic        btn_mode,
    input  logic        btn_set,
    input  logic        btn_inc,
    input  logic [13:0] clk_hour,
    input  logic [13:0] clk_min,
    input  logic [13:0] clk_sec,
    input  logic [20:0] clk_milli,
    input  logic [13:0] sw_hour,
    input  logic [13:0] sw_min,
    input  logic [13:0] sw_sec,
    input  logic [20:0] sw_milli,
    input  logic [13:0] tmr_hour,
    input  logic [13:0] tmr_min,
    input  logic [13:0] tmr_sec,
    input  logic [20:0] tmr_milli,
    output logic [13:0] hourSeg,
    output logic [13:0] minSeg,
    output logic [13:0] secSeg,
    output logic [20:0] milliSeg,
    output logic [1:0]  SEL,
    output logic        inc_hour,
    output logic        inc_min,
    output logic        inc_sec,
    output logic        sw_toggle,
    output logic        tmr_toggle,
    output logic [2:0]  mode
);
    // state        | meaning
    // ST_CLOCK     | wall clock shown
    // ST_STOPWATCH | stopwatch shown, inc toggles run/stop
    // ST_TIMER     | countdown timer shown, inc toggles run/stop
    // ST_SET_HOUR  | editing clock hours, hour field blinks
    // ST_SET_MIN   | editing clock minutes, minute field blinks
    // ST_SET_SEC   | editing clock seconds, second field blinks
    typedef enum logic [2:0] {
        ST_CLOCK     = 3'd0,
        ST_STOPWATCH = 3'd1,
        ST_TIMER     = 3'd2,
        ST_SET_HOUR  = 3'd3,
        ST_SET_MIN   = 3'd4,
        ST_SET_SEC   = 3'd5
    } state_t;

    state_t           r_state;
    logic             r_mode_prev, r_set_prev, r_inc_prev;
    logic [CNT_W-1:0] r_blink_cnt, r_idle_cnt;
    logic             r_phase;

    logic             w_press_mode, w_press_set, w_press_inc, w_any_press;
    logic             w_inc_cmd, w_in_set, w_timeout, w_restart;
    logic [13:0]      w_src_hour, w_src_min, w_src_sec;
    logic [20:0]      w_src_milli;

    assign w_press_mode = btn_mode & ~r_mode_prev;
    assign w_press_set  = btn_set  & ~r_set_prev;
    assign w_press_inc  = btn_inc  & ~r_inc_prev;
    assign w_any_press  = w_press_mode | w_press_set | w_press_inc;
    assign w_inc_cmd    = w_press_inc & ~w_press_set & ~w_press_mode;
    assign w_in_set     = (r_state == ST_SET_HOUR) || (r_state == ST_SET_MIN) ||
                          (r_state == ST_SET_SEC);
    // The tick that brings idle_cnt to TIMEOUT_MS leaves the set state on that same edge.
    assign w_timeout    = w_in_set && tick_ms && !w_any_press &&
                          (r_idle_cnt == CNT_W'(TIMEOUT_MS - 1));
    // Every set press changes state, so it doubles as the counter restart.
    assign w_restart    = w_press_set | w_timeout;
    assign mode         = r_state;

    always_comb begin
        w_src_hour  = clk_hour;
        w_src_min   = clk_min;
        w_src_sec   = clk_sec;
        w_src_milli = clk_milli;
        case (r_state)
            ST_STOPWATCH: begin
                w_src_hour  = sw_hour;
                w_src_min   = sw_min;
                w_src_sec   = sw_sec;
                w_src_milli = sw_milli;
            end
            ST_TIMER: begin
                w_src_hour  = tmr_hour;
                w_src_min   = tmr_min;
                w_src_sec   = tmr_sec;
                w_src_milli = tmr_milli;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST_BTN) begin
        if (RST_BTN) begin
            r_state     <= ST_CLOCK;
            r_mode_prev <= 1'b0;
            r_set_prev  <= 1'b0;
            r_inc_prev  <= 1'b0;
            r_blink_cnt <= '0;
            r_idle_cnt  <= '0;
            r_phase     <= 1'b0;
            hourSeg     <= '0;
            minSeg      <= '0;
            secSeg      <= '0;
            milliSeg    <= '0;
            SEL         <= 2'b00;
            inc_hour    <= 1'b0;
            inc_min     <= 1'b0;
            inc_sec     <= 1'b0;
            sw_toggle   <= 1'b0;
            tmr_toggle  <= 1'b0;
        end else begin
            r_mode_prev <= btn_mode;
            r_set_prev  <= btn_set;
            r_inc_prev  <= btn_inc;

            inc_hour   <= w_inc_cmd && (r_state == ST_SET_HOUR);
            inc_min    <= w_inc_cmd && (r_state == ST_SET_MIN);
            inc_sec    <= w_inc_cmd && (r_state == ST_SET_SEC);
            sw_toggle  <= w_inc_cmd && (r_state == ST_STOPWATCH);
            tmr_toggle <= w_inc_cmd && (r_state == ST_TIMER);

            hourSeg  <= (r_state == ST_SET_HOUR && r_phase) ? 14'd0 : w_src_hour;
            minSeg   <= (r_state == ST_SET_MIN  && r_phase) ? 14'd0 : w_src_min;
            secSeg   <= (r_state == ST_SET_SEC  && r_phase) ? 14'd0 : w_src_sec;
            milliSeg <= w_in_set ? 21'd0 : w_src_milli;
            case (r_state)
                ST_CLOCK:     SEL <= 2'b00;
                ST_STOPWATCH: SEL <= 2'b01;
                ST_TIMER:     SEL <= 2'b10;
                default:      SEL <= 2'b11;
            endcase

            if (w_restart || !w_in_set) begin
                r_blink_cnt <= '0;
                r_phase     <= 1'b0;
                r_idle_cnt  <= '0;
            end else begin
                if (tick_ms) begin
                    if (r_blink_cnt == CNT_W'(BLINK_MS - 1)) begin
                        r_blink_cnt <= '0;
                        r_phase     <= ~r_phase;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + 1'b1;
                    end
                end
                if (w_any_press)
                    r_idle_cnt <= '0;
                else if (tick_ms)
                    r_idle_cnt <= r_idle_cnt + 1'b1;
            end

            case (r_state)
                ST_CLOCK: begin
                    if (w_press_set)       r_state <= ST_SET_HOUR;
                    else if (w_press_mode) r_state <= ST_STOPWATCH;
                end
                ST_STOPWATCH: begin
                    if (w_press_set)       r_state <= ST_CLOCK;
                    else if (w_press_mode) r_state <= ST_TIMER;
                end
                ST_TIMER: begin
                    if (w_press_set || w_press_mode) r_state <= ST_CLOCK;
                end
                ST_SET_HOUR: begin
                    if (w_press_set)    r_state <= ST_SET_MIN;
                    else if (w_timeout) r_state <= ST_CLOCK;
                end
                ST_SET_MIN: begin
                    if (w_press_set)    r_state <= ST_SET_SEC;
                    else if (w_timeout) r_state <= ST_CLOCK;
                end
                ST_SET_SEC: begin
                    if (w_press_set || w_timeout) r_state <= ST_CLOCK;
                end
                default: r_state <= ST_CLOCK;
            endcase
        end
    end
endmodule

// File: tb/tb_display_mode_ctrl.sv
// Bench for display_mode_ctrl: directed button/tick sequences, a behavioural reference model
// compared every cycle, and hand-computed literal expectations at key points.
`timescale 1ns/1ps
module tb_display_mode_ctrl;
    localparam int BLINK = 4;
    localparam int TMO   = 20;

    logic        CLK = 1'b0;
    logic        RST_BTN = 1'b1;
    logic        tick_ms = 1'b0, btn_mode = 1'b0, btn_set = 1'b0, btn_inc = 1'b0;
    logic [13:0] clk_hour, clk_min, clk_sec, sw_hour, sw_min, sw_sec, tmr_hour, tmr_min, tmr_sec;
    logic [20:0] clk_milli, sw_milli, tmr_milli;
    logic [13:0] hourSeg, minSeg, secSeg;
    logic [20:0] milliSeg;
    logic [1:0]  SEL;
    logic        inc_hour, inc_min, inc_sec, sw_toggle, tmr_toggle;
    logic [2:0]  mode;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 0;

    display_mode_ctrl #(.BLINK_MS(BLINK), .TIMEOUT_MS(TMO), .CNT_W(14)) dut (
        .CLK(CLK), .RST_BTN(RST_BTN), .tick_ms(tick_ms),
        .btn_mode(btn_mode), .btn_set(btn_set), .btn_inc(btn_inc),
        .clk_hour(clk_hour), .clk_min(clk_min), .clk_sec(clk_sec), .clk_milli(clk_milli),
        .sw_hour(sw_hour), .sw_min(sw_min), .sw_sec(sw_sec), .sw_milli(sw_milli),
        .tmr_hour(tmr_hour), .tmr_min(tmr_min), .tmr_sec(tmr_sec), .tmr_milli(tmr_milli),
        .hourSeg(hourSeg), .minSeg(minSeg), .secSeg(secSeg), .milliSeg(milliSeg), .SEL(SEL),
        .inc_hour(inc_hour), .inc_min(inc_min), .inc_sec(inc_sec),
        .sw_toggle(sw_toggle), .tmr_toggle(tmr_toggle), .mode(mode)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode number, ticks seen since entering the current set state,
    // ticks since the last press, and the expected registered outputs.
    logic [2:0]  m_mode, n_mode;
    int          m_blink, n_blink, m_idle, n_idle;
    logic        m_pm, m_ps, m_pi;
    logic [13:0] e_hour, e_min, e_sec, n_hour, n_min, n_sec, s_hour, s_min, s_sec;
    logic [20:0] e_milli, n_milli, s_milli;
    logic [1:0]  e_sel, n_sel;
    logic        e_ih, e_im, e_is, e_sw, e_tm;
    logic        pm, ps, pi, in_set, blank, inc_ok;

    always_comb begin
        pm = btn_mode & ~m_pm;
        ps = btn_set  & ~m_ps;
        pi = btn_inc  & ~m_pi;
        in_set = (m_mode >= 3'd3);
        blank  = in_set && (((m_blink / BLINK) % 2) == 1);
        s_hour = clk_hour; s_min = clk_min; s_sec = clk_sec; s_milli = clk_milli;
        if (m_mode == 3'd1) begin
            s_hour = sw_hour; s_min = sw_min; s_sec = sw_sec; s_milli = sw_milli;
        end else if (m_mode == 3'd2) begin
            s_hour = tmr_hour; s_min = tmr_min; s_sec = tmr_sec; s_milli = tmr_milli;
        end
        n_hour  = (m_mode == 3'd3 && blank) ? 14'd0 : s_hour;
        n_min   = (m_mode == 3'd4 && blank) ? 14'd0 : s_min;
        n_sec   = (m_mode == 3'd5 && blank) ? 14'd0 : s_sec;
        n_milli = in_set ? 21'd0 : s_milli;
        n_sel   = in_set ? 2'd3 : m_mode[1:0];
        inc_ok  = pi && !pm && !ps;
        n_mode  = m_mode;
        if (ps)
            n_mode = (m_mode == 3'd0) ? 3'd3 : (m_mode == 3'd3) ? 3'd4 :
                     (m_mode == 3'd4) ? 3'd5 : 3'd0;
        else if (pm) begin
            if (!in_set) n_mode = (m_mode == 3'd2) ? 3'd0 : m_mode + 3'd1;
        end else if (in_set && tick_ms && !pi && (m_idle + 1 >= TMO))
            n_mode = 3'd0;
        n_blink = 0;
        n_idle  = 0;
        if (n_mode == m_mode && in_set) begin
            n_blink = m_blink + int'(tick_ms);
            n_idle  = (pm || pi) ? 0 : m_idle + int'(tick_ms);
        end
    end

    always @(posedge CLK or posedge RST_BTN) begin
        if (RST_BTN) begin
            m_mode <= 3'd0; m_blink <= 0; m_idle <= 0;
            m_pm <= 1'b0; m_ps <= 1'b0; m_pi <= 1'b0;
            e_hour <= '0; e_min <= '0; e_sec <= '0; e_milli <= '0; e_sel <= '0;
            e_ih <= 1'b0; e_im <= 1'b0; e_is <= 1'b0; e_sw <= 1'b0; e_tm <= 1'b0;
        end else begin
            m_mode <= n_mode; m_blink <= n_blink; m_idle <= n_idle;
            m_pm <= btn_mode; m_ps <= btn_set; m_pi <= btn_inc;
            e_hour <= n_hour; e_min <= n_min; e_sec <= n_sec; e_milli <= n_milli; e_sel <= n_sel;
            e_ih <= inc_ok && m_mode == 3'd3;
            e_im <= inc_ok && m_mode == 3'd4;
            e_is <= inc_ok && m_mode == 3'd5;
            e_sw <= inc_ok && m_mode == 3'd1;
            e_tm <= inc_ok && m_mode == 3'd2;
        end
    end

    always @(negedge CLK) begin
        if (started) begin
            chk("cyc_mode", 32'(mode), 32'(m_mode));
            chk("cyc_hourSeg", 32'(hourSeg), 32'(e_hour));
            chk("cyc_minSeg", 32'(minSeg), 32'(e_min));
            chk("cyc_secSeg", 32'(secSeg), 32'(e_sec));
            chk("cyc_milliSeg", 32'(milliSeg), 32'(e_milli));
            chk("cyc_SEL", 32'(SEL), 32'(e_sel));
            chk("cyc_pulses", {27'd0, inc_hour, inc_min, inc_sec, sw_toggle, tmr_toggle},
                {27'd0, e_ih, e_im, e_is, e_sw, e_tm});
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // which: 0=mode, 1=set, 2=inc
    task automatic press(input int which);
        if (which == 0) btn_mode = 1'b1;
        else if (which == 1) btn_set = 1'b1;
        else btn_inc = 1'b1;
        step();
        btn_mode = 1'b0; btn_set = 1'b0; btn_inc = 1'b0;
        step();
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick_ms = 1'b1;
            step();
            tick_ms = 1'b0;
            step();
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: bench did not finish, limit 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        clk_hour = 14'h1234; clk_min = 14'h0111; clk_sec = 14'h0222; clk_milli = 21'h1ABCDE;
        sw_hour  = 14'h0ABC; sw_min  = 14'h0333; sw_sec  = 14'h0444; sw_milli  = 21'h012345;
        tmr_hour = 14'h2DEF; tmr_min = 14'h0555; tmr_sec = 14'h0666; tmr_milli = 21'h0F0F0F;

        step(); step();
        started = 1;
        @(negedge CLK);
        chk("rst_hourSeg", 32'(hourSeg), 32'h0);
        chk("rst_SEL", 32'(SEL), 32'h0);
        chk("rst_mode", 32'(mode), 32'h0);
        step();
        RST_BTN = 1'b0;
        step();
        @(negedge CLK);
        chk("first_hourSeg", 32'(hourSeg), 32'h1234);

        btn_mode = 1'b1; step(); btn_mode = 1'b0;
        @(negedge CLK);
        chk("mode_after_press", 32'(mode), 32'd1);
        step();
        @(negedge CLK);
        chk("sw_hourSeg", 32'(hourSeg), 32'h0ABC);
        chk("sw_SEL", 32'(SEL), 32'd1);

        press(0); chk("mode_seq_2", 32'(mode), 32'd2);
        chk("tmr_hourSeg", 32'(hourSeg), 32'h2DEF);
        press(0); chk("mode_seq_0", 32'(mode), 32'd0);

        press(1);
        @(negedge CLK);
        chk("set_hour_mode", 32'(mode), 32'd3);
        chk("set_hour_SEL", 32'(SEL), 32'd3);
        chk("set_hour_shown", 32'(hourSeg), 32'h1234);
        chk("set_milli0", 32'(milliSeg), 32'h0);
        for (int k = 1; k <= 12; k++) begin
            clk_min = 14'(k * 3);
            tick(1);
            @(negedge CLK);
            chk("blink_hour", 32'(hourSeg), ((k / 4) % 2 == 1) ? 32'h0 : 32'h1234);
            chk("blink_min_pass", 32'(minSeg), 32'(k * 3));
            chk("blink_milli0", 32'(milliSeg), 32'h0);
        end

        press(1); chk("set_min_mode", 32'(mode), 32'd4);
        press(0); chk("mode_ignored_set_min", 32'(mode), 32'd4);
        press(1); chk("set_sec_mode", 32'(mode), 32'd5);
        btn_inc = 1'b1; step(); btn_inc = 1'b0;
        @(negedge CLK); chk("inc_sec_high", 32'(inc_sec), 32'd1);
        step();
        @(negedge CLK); chk("inc_sec_low", 32'(inc_sec), 32'd0);
        tick(5);
        @(negedge CLK); chk("sec_blank", 32'(secSeg), 32'h0);

        step();
        #1 RST_BTN = 1'b1;
        #1;
        chk("async_rst_mode", 32'(mode), 32'd0);
        chk("async_rst_segs", 32'(hourSeg | minSeg | secSeg), 32'h0);
        chk("async_rst_SEL", 32'(SEL), 32'd0);
        #1 RST_BTN = 1'b0;
        step();

        press(0);
        btn_inc = 1'b1; step(); btn_inc = 1'b0;
        @(negedge CLK); chk("sw_toggle_high", 32'(sw_toggle), 32'd1);
        step();
        @(negedge CLK); chk("sw_toggle_low", 32'(sw_toggle), 32'd0);
        press(0);
        btn_inc = 1'b1; step(); btn_inc = 1'b0;
        @(negedge CLK); chk("tmr_toggle_high", 32'(tmr_toggle), 32'd1);
        step();
        @(negedge CLK); chk("tmr_toggle_low", 32'(tmr_toggle), 32'd0);
        press(0);
        btn_inc = 1'b1; step(); btn_inc = 1'b0;
        @(negedge CLK);
        chk("clock_no_pulse", {27'd0, inc_hour, inc_min, inc_sec, sw_toggle, tmr_toggle}, 32'd0);
        step();

        press(0);
        cnt = 0;
        btn_inc = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (sw_toggle) cnt++;
        end
        btn_inc = 1'b0;
        step();
        chk("held_inc_pulses", 32'(cnt), 32'd1);
        press(1); chk("sw_set_to_clock", 32'(mode), 32'd0);

        press(1);
        btn_set = 1'b1; btn_inc = 1'b1; step(); btn_set = 1'b0; btn_inc = 1'b0;
        @(negedge CLK);
        chk("set_inc_mode", 32'(mode), 32'd4);
        chk("set_inc_no_inc_hour", 32'(inc_hour), 32'd0);
        step();
        @(negedge CLK); chk("set_inc_no_inc_late", 32'(inc_hour | inc_min), 32'd0);
        press(1); press(1);
        chk("back_to_clock", 32'(mode), 32'd0);
        btn_set = 1'b1; btn_mode = 1'b1; step(); btn_set = 1'b0; btn_mode = 1'b0;
        @(negedge CLK); chk("set_mode_prio", 32'(mode), 32'd3);
        step();

        press(1);
        tick(TMO - 1);
        @(negedge CLK); chk("timeout_19", 32'(mode), 32'd4);
        tick(1);
        @(negedge CLK); chk("timeout_20", 32'(mode), 32'd0);
        press(1); press(1);
        tick(TMO - 1);
        press(2);
        tick(TMO - 1);
        @(negedge CLK); chk("restart_19", 32'(mode), 32'd4);
        tick(1);
        @(negedge CLK); chk("restart_20", 32'(mode), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
